reg_bus_arbiter: RTL

//  Shares the peripheral register bus between NumMst requesters (AXI-to-reg bridge, debug path, ...) and

---
 rtl/reg_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// core_v_mcu_pkg (subset)
//   Register bus request/response types and the peripheral register map.
//   Slaves: 0 SOC_CTRL, 1 BOOTROM, 2 GPIO, 3 UART, 4 I2C.
//   A rule hits when start_addr <= addr < end_addr.
// -----------------------------------------------------------------------------
package core_v_mcu_pkg;

  localparam int unsigned NumRegSlaves = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef rule_t [NumRegSlaves-1:0] reg_map_t;

  function automatic reg_map_t gen_reg_map();
    reg_map_t m;
    m[0] = '{start_addr: 32'h0002_0000, end_addr: 32'h0002_1000}; // SOC_CTRL
    m[1] = '{start_addr: 32'h0003_0000, end_addr: 32'h0003_4000}; // BOOTROM
    m[2] = '{start_addr: 32'h1000_0000, end_addr: 32'h1000_1000}; // GPIO
    m[3] = '{start_addr: 32'h1002_0000, end_addr: 32'h1002_1000}; // UART
    m[4] = '{start_addr: 32'h1003_0000, end_addr: 32'h1003_1000}; // I2C
    return m;
  endfunction

  localparam reg_map_t RegMap = gen_reg_map();

endpackage

// -----------------------------------------------------------------------------
// reg_bus_arbiter
//   Shares the peripheral register bus between NumMst requesters and routes
//   each granted access to one of NumSlv register slaves. Round-robin grant,
//   a single access in flight, decode error for unmapped addresses and a
//   timeout error for slaves that never answer.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   mst_req_i  requester requests (addr, write, wdata, wstrb, valid)
//   mst_rsp_o  requester responses (rdata, error, ready); one-cycle ready
//   slv_req_o  slave requests; only the selected slave sees valid
//   slv_rsp_i  slave responses
//   busy_o     high whenever the FSM is not IDLE
//   decerr_o   one-cycle pulse: an unmapped address was decoded
//   timeout_o  one-cycle pulse: the selected slave timed out
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
  parameter int unsigned NumMst        = 2,
  parameter int unsigned NumSlv        = core_v_mcu_pkg::NumRegSlaves,
  parameter core_v_mcu_pkg::rule_t [NumSlv-1:0] Map = core_v_mcu_pkg::RegMap,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  core_v_mcu_pkg::reg_req_t [NumMst-1:0] mst_req_i,
  output core_v_mcu_pkg::reg_rsp_t [NumMst-1:0] mst_rsp_o,
  output core_v_mcu_pkg::reg_req_t [NumSlv-1:0] slv_req_o,
  input  core_v_mcu_pkg::reg_rsp_t [NumSlv-1:0] slv_rsp_i,
  output logic                                  busy_o,
  output logic                                  decerr_o,
  output logic                                  timeout_o
);

  localparam int unsigned MstW = (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam int unsigned SlvW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [MstW-1:0] MstLast = MstW'(NumMst - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [MstW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [MstW-1:0]          grant_q, grant_d;
  logic [SlvW-1:0]          sel_q, sel_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  core_v_mcu_pkg::reg_req_t req_q, req_d;
  logic [31:0]              rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     decerr_q, decerr_d;
  logic                     timeout_q, timeout_d;

  logic                     win_found_s;
  logic [MstW-1:0]          win_idx_s;
  logic [MstW-1:0]          scan_idx_s;
  logic [31:0]              win_addr_s;
  logic                     dec_found_s;
  logic [SlvW-1:0]          dec_idx_s;

  // Round-robin pick: first valid requester scanning from rr_ptr upwards, modulo NumMst.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < NumMst; k++) begin
      scan_idx_s = MstW'((32'(rr_ptr_q) + k) % NumMst);
      if (!win_found_s && mst_req_i[scan_idx_s].valid) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_addr_s = mst_req_i[win_idx_s].addr;

  // Address decode of the winning request; the lowest matching map index wins on overlap.
  always_comb begin
    dec_found_s = 1'b0;
    dec_idx_s   = '0;
    for (int i = 0; i < NumSlv; i++) begin
      if (!dec_found_s && (win_addr_s >= Map[i].start_addr) && (win_addr_s < Map[i].end_addr)) begin
        dec_found_s = 1'b1;
        dec_idx_s   = SlvW'(i);
      end else begin
        dec_found_s = dec_found_s;
      end
    end
  end

  // Next-state logic for the IDLE -> ACCESS -> RESP access sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    decerr_d    = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found_s) begin
          // Requester fields are captured here only; later changes cannot disturb the access.
          grant_d = win_idx_s;
          req_d   = mst_req_i[win_idx_s];
          cnt_d   = '0;
          if (dec_found_s) begin
            sel_d   = dec_idx_s;
            state_d = StAccess;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
            decerr_d    = 1'b1;
            state_d     = StResp;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        // Ready is checked before the timeout so a last-cycle ready still completes normally.
        if (slv_rsp_i[sel_q].ready) begin
          rsp_rdata_d = slv_rsp_i[sel_q].rdata;
          rsp_err_d   = slv_rsp_i[sel_q].error;
          state_d     = StResp;
        end else if (cnt_q == CntLast) begin
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b1;
          timeout_d   = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        rr_ptr_d = (grant_q == MstLast) ? '0 : grant_q + MstW'(1);
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      decerr_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      decerr_q    <= decerr_d;
      timeout_q   <= timeout_d;
    end
  end

  // Bus outputs are decoded from registered state only, never from mst_req_i.
  always_comb begin
    slv_req_o = '0;
    mst_rsp_o = '0;
    if (state_q == StAccess) begin
      slv_req_o[sel_q] = req_q;
    end else begin
      slv_req_o = '0;
    end
    if (state_q == StResp) begin
      mst_rsp_o[grant_q].rdata = rsp_rdata_q;
      mst_rsp_o[grant_q].error = rsp_err_q;
      mst_rsp_o[grant_q].ready = 1'b1;
    end else begin
      mst_rsp_o = '0;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign decerr_o  = decerr_q;
  assign timeout_o = timeout_q;

endmodule
